// File: rtl/audio_rec_ctrl.sv
// audio_rec_ctrl: records codec samples into external SRAM and plays them back.
//
// Ports
//   i_clk, i_reset      : system clock and asynchronous active-high reset
//   i_rec_start         : pulse that starts a recording at address 0
//   i_play_start        : pulse that starts playback at address 0
//   i_stop              : pulse that ends the current operation
//   i_adc_valid/i_adc_data : new PCM sample from the codec receiver
//   i_dac_req           : codec transmitter requests the next sample
//   o_dac_data/o_dac_valid : playback sample and its one-cycle update strobe
//   o_mem_write/o_mem_read/o_mem_addr/o_mem_wdata/i_mem_rdata : SRAM controller side
//   o_state             : 00 IDLE, 01 REC, 10 PLAY, 11 PLAY_WAIT
//   o_rec_len           : number of words stored by the last recording
//   o_full              : last recording stopped at MAX_ADDR
//
// Build option
//   AUDIO_LOOP_PLAY_EN  : when defined, playback wraps to address 0 at rec_len
//                         and runs until stop; otherwise playback ends at rec_len.

module audio_rec_ctrl #(
  parameter logic [19:0] MAX_ADDR = 20'hFFFFF,
  parameter int unsigned RD_LAT   = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rec_start,
  input  logic        i_play_start,
  input  logic        i_stop,
  input  logic        i_adc_valid,
  input  logic [15:0] i_adc_data,
  input  logic        i_dac_req,
  output logic [15:0] o_dac_data,
  output logic        o_dac_valid,
  output logic        o_mem_write,
  output logic        o_mem_read,
  output logic [19:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic [15:0] i_mem_rdata,
  output logic [1:0]  o_state,
  output logic [19:0] o_rec_len,
  output logic        o_full
);

  localparam int unsigned AW    = 20;
  localparam int unsigned DW    = 16;
  localparam int unsigned LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_REC       = 2'b01,
    S_PLAY      = 2'b10,
    S_PLAY_WAIT = 2'b11
  } state_t;

  state_t           r_state,     w_state_nxt;
  logic [AW-1:0]    r_wr_ptr,    w_wr_ptr_nxt;
  logic [AW-1:0]    r_rd_ptr,    w_rd_ptr_nxt;
  logic [AW-1:0]    r_rec_len,   w_rec_len_nxt;
  logic             r_full,      w_full_nxt;
  logic             r_mem_write, w_mem_write_nxt;
  logic             r_mem_read,  w_mem_read_nxt;
  logic [AW-1:0]    r_mem_addr,  w_mem_addr_nxt;
  logic [DW-1:0]    r_mem_wdata, w_mem_wdata_nxt;
  logic [DW-1:0]    r_dac_data,  w_dac_data_nxt;
  logic             r_dac_valid, w_dac_valid_nxt;
  logic [LAT_W-1:0] r_lat_cnt,   w_lat_cnt_nxt;
  logic [AW-1:0]    w_rd_inc;

  assign w_rd_inc = r_rd_ptr + AW'(1);

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rec_len   <= '0;
      r_full      <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_dac_data  <= '0;
      r_dac_valid <= 1'b0;
      r_lat_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_rec_len   <= w_rec_len_nxt;
      r_full      <= w_full_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_dac_data  <= w_dac_data_nxt;
      r_dac_valid <= w_dac_valid_nxt;
      r_lat_cnt   <= w_lat_cnt_nxt;
    end
  end

  // Next-state and registered-output logic; stop always wins
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_rec_len_nxt   = r_rec_len;
    w_full_nxt      = r_full;
    w_mem_write_nxt = 1'b0;
    w_mem_read_nxt  = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_dac_data_nxt  = r_dac_data;
    w_dac_valid_nxt = 1'b0;
    w_lat_cnt_nxt   = r_lat_cnt;

    case (r_state)
      S_IDLE: begin
        if (!i_stop) begin
          if (i_rec_start) begin
            w_state_nxt   = S_REC;
            w_wr_ptr_nxt  = '0;
            w_rec_len_nxt = '0;
            w_full_nxt    = 1'b0;
          end else if (i_play_start && (r_rec_len != '0)) begin
            w_state_nxt  = S_PLAY;
            w_rd_ptr_nxt = '0;
          end
        end
      end

      S_REC: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
        end else if (i_adc_valid) begin
          w_mem_write_nxt = 1'b1;
          w_mem_addr_nxt  = r_wr_ptr;
          w_mem_wdata_nxt = i_adc_data;
          w_rec_len_nxt   = r_wr_ptr + AW'(1);
          // Last word: leave REC together with the final write strobe
          if (r_wr_ptr == MAX_ADDR) begin
            w_full_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + AW'(1);
          end
        end
      end

      S_PLAY: begin
        if (i_stop) begin
          w_state_nxt = S_IDLE;
        end else if (i_dac_req) begin
          w_mem_read_nxt = 1'b1;
          w_mem_addr_nxt = r_rd_ptr;
          w_lat_cnt_nxt  = '0;
          w_state_nxt    = S_PLAY_WAIT;
        end
      end

      S_PLAY_WAIT: begin
        // Counter equals the number of cycles since the read strobe
        if (i_stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_lat_cnt == LAT_W'(RD_LAT)) begin
          w_dac_data_nxt  = i_mem_rdata;
          w_dac_valid_nxt = 1'b1;
          if (w_rd_inc == r_rec_len) begin
            w_rd_ptr_nxt = '0;
`ifdef AUDIO_LOOP_PLAY_EN
            w_state_nxt  = S_PLAY;
`else
            w_state_nxt  = S_IDLE;
`endif
          end else begin
            w_rd_ptr_nxt = w_rd_inc;
            w_state_nxt  = S_PLAY;
          end
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_state     = r_state;
  assign o_rec_len   = r_rec_len;
  assign o_full      = r_full;
  assign o_mem_write = r_mem_write;
  assign o_mem_read  = r_mem_read;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_dac_data  = r_dac_data;
  assign o_dac_valid = r_dac_valid;

endmodule

// File: tb/tb_audio_rec_ctrl.sv
// Directed bench for audio_rec_ctrl: a default-size instance with a small
// SRAM model (read latency 2) and a MAX_ADDR=3 instance for the full case.

module tb_audio_rec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rec_start, play_start, stop, adc_valid, dac_req;
  logic [15:0] adc_data;
  logic [15:0] dac_data, mem_wdata, mem_rdata;
  logic        dac_valid, mem_write, mem_read, full;
  logic [19:0] mem_addr, rec_len;
  logic [1:0]  state;

  logic        s_rec_start, s_adc_valid;
  logic [15:0] s_adc_data;
  logic [15:0] s_dac_data, s_mem_wdata;
  logic        s_dac_valid, s_mem_write, s_mem_read, s_full;
  logic [19:0] s_mem_addr, s_rec_len;
  logic [1:0]  s_state;
  logic        s_zero = 1'b0;
  logic [15:0] s_zero16 = 16'h0;

  int checks = 0;
  int failures = 0;
  int n_wr = 0, n_rd = 0, n_dv = 0, s_n_wr = 0;
  int dv_before;

  logic [15:0] mem [0:15];
  logic        a1_v = 1'b0, a2_v = 1'b0;
  logic [3:0]  a1_a = '0, a2_a = '0;

  always #5 clk = ~clk;

  audio_rec_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_rec_start(rec_start), .i_play_start(play_start),
    .i_stop(stop), .i_adc_valid(adc_valid), .i_adc_data(adc_data), .i_dac_req(dac_req),
    .o_dac_data(dac_data), .o_dac_valid(dac_valid), .o_mem_write(mem_write),
    .o_mem_read(mem_read), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_state(state), .o_rec_len(rec_len), .o_full(full)
  );

  audio_rec_ctrl #(.MAX_ADDR(20'd3), .RD_LAT(2)) dut_s (
    .i_clk(clk), .i_reset(reset), .i_rec_start(s_rec_start), .i_play_start(s_zero),
    .i_stop(s_zero), .i_adc_valid(s_adc_valid), .i_adc_data(s_adc_data), .i_dac_req(s_zero),
    .o_dac_data(s_dac_data), .o_dac_valid(s_dac_valid), .o_mem_write(s_mem_write),
    .o_mem_read(s_mem_read), .o_mem_addr(s_mem_addr), .o_mem_wdata(s_mem_wdata),
    .i_mem_rdata(s_zero16), .o_state(s_state), .o_rec_len(s_rec_len), .o_full(s_full)
  );

  // SRAM model sampled mid-cycle: data for a read in cycle M appears in cycle M+2
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem_rdata = 16'h0;
  end

  always @(negedge clk) begin
    if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;
    a1_v <= mem_read;
    a1_a <= mem_addr[3:0];
    a2_v <= a1_v;
    a2_a <= a1_a;
    if (a2_v) mem_rdata <= mem[a2_a];
    if (mem_write) n_wr <= n_wr + 1;
    if (mem_read) n_rd <= n_rd + 1;
    if (dac_valid) n_dv <= n_dv + 1;
    if (s_mem_write) s_n_wr <= s_n_wr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample and drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {rec_start, play_start, stop, adc_valid, dac_req} = '0;
    adc_data = '0;
    {s_rec_start, s_adc_valid} = '0;
    s_adc_data = '0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", {mem_write, mem_read, dac_valid, full}, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_reclen", 32'(rec_len), 32'd0);
    chk("rst_dac", 32'(dac_data), 32'd0);
    reset = 1'b0;
    tick();

    // Record 0x0001..0x0005
    rec_start = 1'b1; tick(); rec_start = 1'b0;
    chk("rec_state", 32'(state), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      adc_data = 16'(i); adc_valid = 1'b1; tick(); adc_valid = 1'b0;
      chk("rec_wr", 32'(mem_write), 32'd1);
      chk("rec_addr", 32'(mem_addr), 32'(i - 1));
      chk("rec_wdata", 32'(mem_wdata), 32'(i));
      chk("rec_len_run", 32'(rec_len), 32'(i));
      tick();
      chk("rec_wr_pulse", 32'(mem_write), 32'd0);
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_state", 32'(state), 32'd0);
    chk("stop_reclen", 32'(rec_len), 32'd5);
    chk("stop_full", 32'(full), 32'd0);
    tick();
    chk("rec_nwr", 32'(n_wr), 32'd5);

    // Playback with 10-cycle request spacing
    play_start = 1'b1; tick(); play_start = 1'b0;
    chk("play_state", 32'(state), 32'd2);
    for (int k = 1; k <= 5; k++) begin
      dac_req = 1'b1; tick(); dac_req = 1'b0;
      chk("pl_rd", 32'(mem_read), 32'd1);
      chk("pl_addr", 32'(mem_addr), 32'(k - 1));
      chk("pl_wait", 32'(state), 32'd3);
      tick();
      if (k == 2) dac_req = 1'b1;
      tick(); dac_req = 1'b0;
      chk("pl_early", {mem_read, dac_valid}, 32'd0);
      tick();
      chk("pl_dv", 32'(dac_valid), 32'd1);
      chk("pl_data", 32'(dac_data), 32'(k));
`ifdef AUDIO_LOOP_PLAY_EN
      chk("pl_after", 32'(state), 32'd2);
`else
      chk("pl_after", 32'(state), (k == 5) ? 32'd0 : 32'd2);
`endif
      tick();
      chk("pl_dv_pulse", 32'(dac_valid), 32'd0);
      chk("pl_hold", 32'(dac_data), 32'(k));
      for (int j = 0; j < 5; j++) tick();
    end
    chk("pl_nrd", 32'(n_rd), 32'd5);
    chk("pl_ndv", 32'(n_dv), 32'd5);
    stop = 1'b1; tick(); stop = 1'b0;

`ifdef AUDIO_LOOP_PLAY_EN
    // Wrap-around playback over three words
    rec_start = 1'b1; tick(); rec_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adc_data = 16'(16'h11 + i); adc_valid = 1'b1; tick(); adc_valid = 1'b0; tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("lp_reclen", 32'(rec_len), 32'd3);
    play_start = 1'b1; tick(); play_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      dac_req = 1'b1; tick(); dac_req = 1'b0;
      chk("lp_addr", 32'(mem_addr), 32'(i % 3));
      tick(); tick(); tick();
      chk("lp_data", 32'(dac_data), 32'(16'h11 + (i % 3)));
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("lp_stop", 32'(state), 32'd0);
`endif

    // Asynchronous reset while a read is outstanding
    play_start = 1'b1; tick(); play_start = 1'b0;
    dac_req = 1'b1; tick(); dac_req = 1'b0;
    chk("rw_wait", 32'(state), 32'd3);
    tick();
    dv_before = n_dv;
    reset = 1'b1; #1;
    chk("rw_state", 32'(state), 32'd0);
    chk("rw_outs", {mem_write, mem_read, dac_valid, full}, 32'd0);
    chk("rw_dac", 32'(dac_data), 32'd0);
    chk("rw_reclen", 32'(rec_len), 32'd0);
    tick(); reset = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    chk("rw_nodv", 32'(n_dv), 32'(dv_before));

    // Playback with empty recording is ignored
    play_start = 1'b1; tick(); play_start = 1'b0;
    chk("empty_state", 32'(state), 32'd0);
    tick(); tick();
    chk("empty_rd", 32'(n_rd), 32'd6);

    // Start priorities
    rec_start = 1'b1; play_start = 1'b1; tick(); rec_start = 1'b0; play_start = 1'b0;
    chk("prio_rec", 32'(state), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("prio_stop", 32'(state), 32'd0);
    rec_start = 1'b1; stop = 1'b1; tick(); rec_start = 1'b0; stop = 1'b0;
    chk("prio_stop_idle", 32'(state), 32'd0);
    chk("prio_reclen", 32'(rec_len), 32'd0);

    // Small memory fills after four words
    s_rec_start = 1'b1; tick(); s_rec_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_adc_data = 16'(16'hA0 + i); s_adc_valid = 1'b1; tick(); s_adc_valid = 1'b0;
      if (i == 3) begin
        chk("full_last_wr", 32'(s_mem_write), 32'd1);
        chk("full_last_addr", 32'(s_mem_addr), 32'd3);
        chk("full_same_cyc", {s_state, s_full}, 32'b001);
      end
      if (i == 4) chk("full_no_wr", 32'(s_mem_write), 32'd0);
      tick();
    end
    chk("full_nwr", 32'(s_n_wr), 32'd4);
    chk("full_flag", 32'(s_full), 32'd1);
    chk("full_reclen", 32'(s_rec_len), 32'd4);
    chk("full_state", 32'(s_state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
